// File: rtl/score_keeper.sv
// Pong match scorer: turns point pulses into per-player BCD scores and sequences
// idle / play / post-point hold / game over, driving the two score digits.
module score_keeper #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic       play_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] p1score,
  output logic [3:0] p2score
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [SCORE_W-1:0] MAX_DIGIT  = SCORE_W'(9);
  localparam logic [SCORE_W-1:0] BLANK      = SCORE_W'(10);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score1_q, score1_d;
  logic [SCORE_W-1:0]   score2_q, score2_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_shown_q, blink_shown_d;
  logic                 serve_d, winner_d;
  logic [SCORE_W-1:0]   disp1_d, disp2_d;
  logic [SCORE_W-1:0]   scorer_score;

  // Edge-detect history; armed blocks events on the first cycle after reset
  // release so a button held through reset does not fire.
  logic armed_q;
  logic start_q, p1_q, p2_q;
  logic start_ev, p1_ev, p2_ev;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= MAX_DIGIT) ? MAX_DIGIT : s + SCORE_W'(1);
  endfunction

  always_comb begin
    start_ev = armed_q & start    & ~start_q;
    p1_ev    = armed_q & p1_point & ~p1_q;
    p2_ev    = armed_q & p2_point & ~p2_q;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    hold_cnt_d    = hold_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_shown_d = blink_shown_q;
    serve_d       = serve_dir;
    winner_d      = winner;
    disp1_d       = '0;
    disp2_d       = '0;
    scorer_score  = serve_dir ? score1_q : score2_q;

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          state_d  = S_PLAY;
          score1_d = '0;
          score2_d = '0;
          serve_d  = 1'b0;
        end
      end

      S_PLAY: begin
        if (p1_ev && !p2_ev) begin
          score1_d   = sat_inc(score1_q);
          serve_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end else if (p2_ev && !p1_ev) begin
          score2_d   = sat_inc(score2_q);
          serve_d    = 1'b0;
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end
      end

      // serve_dir still encodes who just scored: 1 means player 1 did.
      S_HOLD: begin
        if (scorer_score == WIN) begin
          state_d       = S_OVER;
          winner_d      = ~serve_dir;
          blink_cnt_d   = '0;
          blink_shown_d = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_PLAY;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      S_OVER: begin
        if (start_ev) begin
          state_d       = S_PLAY;
          score1_d      = '0;
          score2_d      = '0;
          serve_d       = ~winner;
          blink_cnt_d   = '0;
          blink_shown_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = '0;
          blink_shown_d = ~blink_shown_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Display codes follow the next state so they update with it.
    if (state_d != S_IDLE) begin
      disp1_d = score1_d;
      disp2_d = score2_d;
    end
    if (state_d == S_OVER && !blink_shown_d) begin
      if (winner_d) disp2_d = BLANK;
      else          disp1_d = BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      start_q <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      start_q <= start;
      p1_q    <= p1_point;
      p2_q    <= p2_point;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      score1_q      <= '0;
      score2_q      <= '0;
      hold_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_shown_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      hold_cnt_q    <= hold_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_shown_q <= blink_shown_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_en   <= 1'b0;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      p1score   <= '0;
      p2score   <= '0;
    end else begin
      play_en   <= (state_d == S_PLAY);
      serve_dir <= serve_d;
      game_over <= (state_d == S_OVER);
      winner    <= winner_d;
      p1score   <= disp1_d;
      p2score   <= disp2_d;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a match-level model is compared against
// the DUT every cycle, plus directed literal checks that pin the model.
module tb_score_keeper;

  localparam int WIN   = 3;
  localparam int HOLD  = 4;
  localparam int BLINK = 3;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_HOLD = 2;
  localparam int M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       play_en, serve_dir, game_over, winner;
  logic [3:0] p1score, p2score;

  score_keeper #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLD),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .p1_point (p1_point),
    .p2_point (p2_point),
    .play_en  (play_en),
    .serve_dir(serve_dir),
    .game_over(game_over),
    .winner   (winner),
    .p1score  (p1score),
    .p2score  (p2score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Match-level model
  int m_mode, m_s1, m_s2, m_scorer, m_win, m_serve, m_hold_age, m_go_age;
  int m_ps, m_p1, m_p2, m_live;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_scorer = 0; m_win = 0; m_serve = 0;
    m_hold_age = 0; m_go_age = 0; m_ps = 0; m_p1 = 0; m_p2 = 0; m_live = 0;
  endtask

  function automatic int bump(input int s);
    return (s + 1 > 9) ? 9 : s + 1;
  endfunction

  task automatic model_update();
    int es, e1, e2;
    es = (m_live != 0 && start    && m_ps == 0) ? 1 : 0;
    e1 = (m_live != 0 && p1_point && m_p1 == 0) ? 1 : 0;
    e2 = (m_live != 0 && p2_point && m_p2 == 0) ? 1 : 0;
    case (m_mode)
      M_IDLE: if (es != 0) begin
        m_mode = M_PLAY; m_s1 = 0; m_s2 = 0; m_serve = 0;
      end
      M_PLAY: if (e1 + e2 == 1) begin
        m_scorer = (e1 != 0) ? 0 : 1;
        if (m_scorer == 0) m_s1 = bump(m_s1); else m_s2 = bump(m_s2);
        m_serve = 1 - m_scorer;
        m_mode = M_HOLD;
        m_hold_age = 0;
      end
      M_HOLD: begin
        if (((m_scorer == 0) ? m_s1 : m_s2) == WIN) begin
          m_mode = M_OVER; m_win = m_scorer; m_go_age = 0;
        end else begin
          m_hold_age++;
          if (m_hold_age == HOLD) m_mode = M_PLAY;
        end
      end
      default: begin
        if (es != 0) begin
          m_mode = M_PLAY; m_s1 = 0; m_s2 = 0; m_serve = 1 - m_win;
        end else m_go_age++;
      end
    endcase
    m_ps = int'(start); m_p1 = int'(p1_point); m_p2 = int'(p2_point);
    m_live = 1;
  endtask

  function automatic int exp_digit(input int player);
    if (m_mode == M_OVER && m_win == player && ((m_go_age / BLINK) % 2) == 1)
      return 10;
    return (player == 0) ? m_s1 : m_s2;
  endfunction

  task automatic compare_all();
    check("play_en",   int'(play_en),   (m_mode == M_PLAY) ? 1 : 0);
    check("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    check("serve_dir", int'(serve_dir), m_serve);
    check("winner",    int'(winner),    m_win);
    check("p1score",   int'(p1score),   exp_digit(0));
    check("p2score",   int'(p2score),   exp_digit(1));
  endtask

  // One clock: model advances on the rising edge, compare on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset) model_update();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse_p1();
    p1_point = 1'b1; step(1); p1_point = 1'b0;
  endtask

  task automatic pulse_p2();
    p2_point = 1'b1; step(1); p2_point = 1'b0;
  endtask

  int low_cnt;
  int rec [7];
  int exp_blink [7] = '{3, 3, 3, 10, 10, 10, 3};

  initial begin
    model_reset();
    #2 reset = 1'b0;
    step(3);
    check("rst p1score", int'(p1score), 0);
    check("rst play_en", int'(play_en), 0);
    reset = 1'b1;
    step(2);

    // Points in IDLE are ignored
    pulse_p1();
    step(1);
    check("idle p1score", int'(p1score), 0);
    check("idle play_en", int'(play_en), 0);

    // Start, then a 10-cycle-long point
    start = 1'b1; step(1); start = 1'b0;
    check("start play_en", int'(play_en), 1);
    step(2);
    p1_point = 1'b1;
    step(1);
    check("pt p1score", int'(p1score), 1);
    check("pt serve_dir", int'(serve_dir), 1);
    low_cnt = (play_en == 1'b0) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (!play_en) low_cnt++;
    end
    p1_point = 1'b0;
    check("hold low cycles", low_cnt, 4);
    check("held p1score", int'(p1score), 1);
    step(1);

    // Simultaneous points cancel
    p1_point = 1'b1; p2_point = 1'b1; step(1);
    p1_point = 1'b0; p2_point = 1'b0;
    check("sim p1score", int'(p1score), 1);
    check("sim p2score", int'(p2score), 0);
    check("sim play_en", int'(play_en), 1);
    step(1);

    // Player 2 wins 3-1
    for (int k = 1; k < WIN; k++) begin
      pulse_p2();
      step(HOLD);
      check("between play_en", int'(play_en), 1);
    end
    pulse_p2();
    step(1);
    check("go game_over", int'(game_over), 1);
    check("go winner", int'(winner), 1);
    check("go play_en", int'(play_en), 0);
    rec[0] = int'(p2score);
    for (int i = 1; i < 7; i++) begin
      step(1);
      rec[i] = int'(p2score);
      check("go p1 steady", int'(p1score), 1);
    end
    for (int i = 0; i < 7; i++) check("blink p2score", rec[i], exp_blink[i]);

    // Restart: loser serves
    start = 1'b1; step(1); start = 1'b0;
    check("rs p1score", int'(p1score), 0);
    check("rs p2score", int'(p2score), 0);
    check("rs game_over", int'(game_over), 0);
    check("rs play_en", int'(play_en), 1);
    check("rs serve_dir", int'(serve_dir), 0);
    step(1);

    // Reach 2/1 in HOLD, then reset asynchronously
    pulse_p2(); step(HOLD);
    pulse_p1(); step(HOLD);
    pulse_p1();
    check("pre p1score", int'(p1score), 2);
    step(1);
    reset = 1'b0;
    start = 1'b1;
    #1;
    check("async play_en", int'(play_en), 0);
    check("async game_over", int'(game_over), 0);
    check("async winner", int'(winner), 0);
    check("async serve_dir", int'(serve_dir), 0);
    check("async p1score", int'(p1score), 0);
    check("async p2score", int'(p2score), 0);
    model_reset();
    step(2);
    reset = 1'b1;
    step(4);
    check("held start play_en", int'(play_en), 0);
    start = 1'b0; step(1);
    start = 1'b1; step(1);
    check("repress play_en", int'(play_en), 1);
    start = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
